// File: rtl/cpu_rf_wrport_arbiter.sv
// cpu_rf_wrport_arbiter
//   Shares the register file's single write port between normal writeback
//   and the interrupt save of the return address (PC+4) into XP_REG.
//   Writeback normally wins. A pending save that loses arbitration
//   DEFER_MAX times forces a CPU stall, so the save goes through on the
//   first stalled cycle. This block also owns the IRQ sequencing into
//   kernel mode: IDLE -> SAVE -> BLOCK -> IDLE.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   wb_we/addr/data   writeback write request
//   irq               level interrupt request
//   pc                current PC, pc[31]=1 means kernel mode
//   rf_we/addr/data   register file write port (combinational mux)
//   irq_ack           one-cycle pulse after the save is committed
//   stall             CPU must hold; writeback ignored while high
//   busy              state != IDLE
module cpu_rf_wrport_arbiter #(
  parameter logic [4:0] XP_REG    = 5'd26,
  parameter int         DEFER_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        irq,
  input  logic [31:0] pc,
  output logic        rf_we,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_data,
  output logic        irq_ack,
  output logic        stall,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SAVE  = 2'd1,
    BLOCK = 2'd2
  } state_t;

  localparam logic [2:0] DMAX = 3'(DEFER_MAX);

  state_t      state, state_nx;
  logic [31:0] epc_q, epc_nx;
  logic [2:0]  defer_cnt, cnt_nx;
  logic        ack_nx, stall_nx;
  logic        wb_eff, grant;
  logic [2:0]  cnt_inc;

  // r0 writes are dropped and a stalled CPU's writeback is not real.
  assign wb_eff  = wb_we & (wb_addr != 5'd0) & ~stall;
  assign grant   = (state == SAVE) & (~wb_eff | (defer_cnt == DMAX));
  assign cnt_inc = defer_cnt + 3'd1;
  assign busy    = (state != IDLE);

  // Write-port mux; gated by reset so a save pending at reset never lands.
  always_comb begin
    rf_we   = 1'b0;
    rf_addr = wb_addr;
    rf_data = wb_data;
    if (!reset) begin
      if (grant) begin
        rf_we   = 1'b1;
        rf_addr = XP_REG;
        rf_data = epc_q;
      end else begin
        rf_we   = wb_eff;
      end
    end
  end

  always_comb begin
    state_nx = state;
    epc_nx   = epc_q;
    cnt_nx   = defer_cnt;
    ack_nx   = 1'b0;
    stall_nx = stall;
    case (state)
      IDLE: begin
        stall_nx = 1'b0;
        // Kernel mode is not interruptible.
        if (irq && !pc[31]) begin
          epc_nx   = {pc[31], pc[30:0] + 31'd4};
          cnt_nx   = 3'd0;
          state_nx = SAVE;
        end
      end
      SAVE: begin
        if (grant) begin
          state_nx = BLOCK;
          cnt_nx   = 3'd0;
          ack_nx   = 1'b1;
          stall_nx = 1'b0;
        end else begin
          cnt_nx   = cnt_inc;
          // Raise stall one cycle ahead so the forced grant lands on the
          // first stalled cycle.
          stall_nx = (cnt_inc == DMAX);
        end
      end
      BLOCK: begin
        stall_nx = 1'b0;
        if (pc[31]) state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        stall_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      epc_q     <= 32'd0;
      defer_cnt <= 3'd0;
      irq_ack   <= 1'b0;
      stall     <= 1'b0;
    end else begin
      state     <= state_nx;
      epc_q     <= epc_nx;
      defer_cnt <= cnt_nx;
      irq_ack   <= ack_nx;
      stall     <= stall_nx;
    end
  end

endmodule
